// File: rtl/video_timings_pkg.sv
// Shared timing-set type, power-on default mode (640x480@60) and compare helper
// for the multi-mode video timing generator.
package video_timings_pkg;

    localparam int unsigned VT_DIVBITS = 4;
    localparam int unsigned VT_HBITS   = 12;
    localparam int unsigned VT_VBITS   = 12;

    typedef struct packed {
        logic [VT_DIVBITS-1:0] clkdiv;
        logic [VT_HBITS-1:0]   hbstart;
        logic [VT_HBITS-1:0]   hsstart;
        logic [VT_HBITS-1:0]   hsstop;
        logic [VT_HBITS-1:0]   htotal;
        logic [VT_VBITS-1:0]   vbstart;
        logic [VT_VBITS-1:0]   vsstart;
        logic [VT_VBITS-1:0]   vsstop;
        logic [VT_VBITS-1:0]   vtotal;
        logic                  hpolarity;
        logic                  vpolarity;
        logic                  interlace;
    } vt_timings_t;

    localparam vt_timings_t VT_DEFAULT = '{
        clkdiv:    4'd3,
        hbstart:   12'd640,
        hsstart:   12'd656,
        hsstop:    12'd752,
        htotal:    12'd800,
        vbstart:   12'd480,
        vsstart:   12'd490,
        vsstop:    12'd492,
        vtotal:    12'd525,
        hpolarity: 1'b0,
        vpolarity: 1'b0,
        interlace: 1'b0
    };

    function automatic logic vt_equal(input vt_timings_t a, input vt_timings_t b);
        return a == b;
    endfunction

endpackage

// File: rtl/vt_pixel_div.sv
// Pixel clock divider: adv_o marks the pixel-advance cycle, pixel_stb_o is its
// registered one-cycle pulse. Shared with the OSD.
module vt_pixel_div #(
    parameter int unsigned DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DIV_BITS-1:0] div_i,
    output logic                adv_o,
    output logic                pixel_stb_o
);

    logic [DIV_BITS-1:0] divcnt_q, divcnt_d;
    logic                pixel_stb_q, pixel_stb_d;

    always_comb begin
        adv_o       = (divcnt_q >= div_i);
        divcnt_d    = adv_o ? '0 : divcnt_q + 1'b1;
        pixel_stb_d = adv_o;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divcnt_q    <= '0;
            pixel_stb_q <= 1'b0;
        end else begin
            divcnt_q    <= divcnt_d;
            pixel_stb_q <= pixel_stb_d;
        end
    end

    assign pixel_stb_o = pixel_stb_q;

endmodule

// File: rtl/video_timings_mc.sv
// Multi-mode video timing generator with a frame-boundary shadowed timing set.
// Optional interlace support: define VIDEO_TIMINGS_INTERLACE_EN.
module video_timings_mc
    import video_timings_pkg::*;
#(
    parameter int unsigned DIV_BITS = 4,
    parameter int unsigned H_BITS   = 12,
    parameter int unsigned V_BITS   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  vt_timings_t       timings,
    output logic              pixel_stb,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              hblank_n,
    output logic              vblank_n,
    output logic              hblank_stb,
    output logic              vblank_stb,
    output logic              line_stb,
    output logic              frame_stb,
    output logic              mode_stb,
    output logic [H_BITS-1:0] xpos,
    output logic [V_BITS-1:0] ypos,
    output logic              field
);

    vt_timings_t       shadow_q, shadow_d, cur;
    logic              load_pending_q;
    logic [H_BITS-1:0] hcnt_q, hcnt_d, hlast;
    logic [V_BITS-1:0] vcnt_q, vcnt_d, vlast;
    logic              field_q, field_d, mode_chg_q, mode_chg_d;
    logic              adv, hwrap, fwrap, hb, vb, hs, vs, vs_line;
`ifdef VIDEO_TIMINGS_INTERLACE_EN
    logic              il;
    logic [H_BITS-1:0] half;
    logic [V_BITS-1:0] vprev;
`endif

    logic              hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic              hblank_n_q, hblank_n_d, vblank_n_q, vblank_n_d;
    logic              hblank_stb_q, hblank_stb_d, vblank_stb_q, vblank_stb_d;
    logic              line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;
    logic              mode_stb_q, mode_stb_d, field_o_q, field_o_d;
    logic [H_BITS-1:0] xpos_q, xpos_d;
    logic [V_BITS-1:0] ypos_q, ypos_d;

    // The first cycle after reset already runs on the requested mode.
    assign cur = load_pending_q ? timings : shadow_q;

    vt_pixel_div #(
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .div_i       (cur.clkdiv),
        .adv_o       (adv),
        .pixel_stb_o (pixel_stb)
    );

    always_comb begin
        // Zero-length totals behave as length one so the counters hold at 0.
        hlast   = (cur.htotal == '0) ? '0 : cur.htotal - 1'b1;
        vlast   = (cur.vtotal == '0) ? '0 : cur.vtotal - 1'b1;
        hb      = (hcnt_q < cur.hbstart);
        vb      = (vcnt_q < cur.vbstart);
        hs      = (hcnt_q >= cur.hsstart) && (hcnt_q < cur.hsstop);
        vs_line = (vcnt_q >= cur.vsstart) && (vcnt_q < cur.vsstop);
        vs      = vs_line;
`ifdef VIDEO_TIMINGS_INTERLACE_EN
        il    = cur.interlace & field_q;
        half  = cur.htotal >> 1;
        vprev = vcnt_q - 1'b1;
        if (il) begin
            vlast = vlast + 1'b1;
            // Odd field: vsync edges shifted by half a line.
            if (hcnt_q < half) begin
                vs = (vprev >= cur.vsstart) && (vprev < cur.vsstop);
            end
        end
`endif
        hwrap = (hcnt_q >= hlast);
        fwrap = hwrap && (vcnt_q >= vlast);

        shadow_d     = load_pending_q ? timings : shadow_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        field_d      = field_q;
        mode_chg_d   = 1'b0;
        mode_stb_d   = mode_chg_q;
        hsync_n_d    = hsync_n_q;
        vsync_n_d    = vsync_n_q;
        hblank_n_d   = hblank_n_q;
        vblank_n_d   = vblank_n_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        field_o_d    = field_o_q;
        hblank_stb_d = 1'b0;
        vblank_stb_d = 1'b0;
        line_stb_d   = 1'b0;
        frame_stb_d  = 1'b0;

        if (adv) begin
            hsync_n_d    = hs ? cur.hpolarity : ~cur.hpolarity;
            vsync_n_d    = vs ? cur.vpolarity : ~cur.vpolarity;
            hblank_n_d   = hb;
            vblank_n_d   = vb;
            xpos_d       = hb ? hcnt_q : '1;
            ypos_d       = vb ? vcnt_q : '1;
            field_o_d    = field_q;
            hblank_stb_d = hblank_n_q & ~hb;
            vblank_stb_d = vblank_n_q & ~vb;
            line_stb_d   = hwrap;
            frame_stb_d  = fwrap;

            if (hwrap) begin
                hcnt_d = '0;
                vcnt_d = fwrap ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            if (fwrap) begin
                shadow_d   = timings;
                mode_chg_d = !vt_equal(timings, cur);
`ifdef VIDEO_TIMINGS_INTERLACE_EN
                field_d    = cur.interlace ? ~field_q : 1'b0;
`else
                field_d    = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= VT_DEFAULT;
            load_pending_q <= 1'b1;
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            field_q        <= 1'b0;
            mode_chg_q     <= 1'b0;
            mode_stb_q     <= 1'b0;
            hsync_n_q      <= ~VT_DEFAULT.hpolarity;
            vsync_n_q      <= ~VT_DEFAULT.vpolarity;
            hblank_n_q     <= 1'b1;
            vblank_n_q     <= 1'b1;
            xpos_q         <= '0;
            ypos_q         <= '0;
            field_o_q      <= 1'b0;
            hblank_stb_q   <= 1'b0;
            vblank_stb_q   <= 1'b0;
            line_stb_q     <= 1'b0;
            frame_stb_q    <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            load_pending_q <= 1'b0;
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            field_q        <= field_d;
            mode_chg_q     <= mode_chg_d;
            mode_stb_q     <= mode_stb_d;
            hsync_n_q      <= hsync_n_d;
            vsync_n_q      <= vsync_n_d;
            hblank_n_q     <= hblank_n_d;
            vblank_n_q     <= vblank_n_d;
            xpos_q         <= xpos_d;
            ypos_q         <= ypos_d;
            field_o_q      <= field_o_d;
            hblank_stb_q   <= hblank_stb_d;
            vblank_stb_q   <= vblank_stb_d;
            line_stb_q     <= line_stb_d;
            frame_stb_q    <= frame_stb_d;
        end
    end

    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign hblank_n   = hblank_n_q;
    assign vblank_n   = vblank_n_q;
    assign hblank_stb = hblank_stb_q;
    assign vblank_stb = vblank_stb_q;
    assign line_stb   = line_stb_q;
    assign frame_stb  = frame_stb_q;
    assign mode_stb   = mode_stb_q;
    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign field      = field_o_q;

endmodule

// File: tb/tb_video_timings_mc.sv
// Scoreboard bench for video_timings_mc: frames of expected pixels are queued by
// the stimulus and checked by a monitor on every pixel_stb.
module tb_video_timings_mc;
    import video_timings_pkg::*;

    localparam vt_timings_t M1 = '{clkdiv: 4'd1, hbstart: 12'd6, hsstart: 12'd7,
        hsstop: 12'd8, htotal: 12'd10, vbstart: 12'd3, vsstart: 12'd4, vsstop: 12'd5,
        vtotal: 12'd5, hpolarity: 1'b0, vpolarity: 1'b0, interlace: 1'b0};
    localparam vt_timings_t M2 = '{clkdiv: 4'd1, hbstart: 12'd6, hsstart: 12'd7,
        hsstop: 12'd8, htotal: 12'd12, vbstart: 12'd3, vsstart: 12'd4, vsstop: 12'd5,
        vtotal: 12'd5, hpolarity: 1'b0, vpolarity: 1'b0, interlace: 1'b0};
    localparam vt_timings_t M3 = '{clkdiv: 4'd0, hbstart: 12'd6, hsstart: 12'd7,
        hsstop: 12'd9, htotal: 12'd12, vbstart: 12'd3, vsstart: 12'd4, vsstop: 12'd5,
        vtotal: 12'd5, hpolarity: 1'b1, vpolarity: 1'b0, interlace: 1'b0};
    localparam vt_timings_t M4 = '{clkdiv: 4'd1, hbstart: 12'd6, hsstart: 12'd7,
        hsstop: 12'd8, htotal: 12'd10, vbstart: 12'd3, vsstart: 12'd4, vsstop: 12'd5,
        vtotal: 12'd5, hpolarity: 1'b0, vpolarity: 1'b0, interlace: 1'b1};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    vt_timings_t timings;
    logic        pixel_stb, hsync_n, vsync_n, hblank_n, vblank_n;
    logic        hblank_stb, vblank_stb, line_stb, frame_stb, mode_stb, field;
    logic [11:0] xpos, ypos;

    typedef struct {
        logic        hs, vs, hb, vb, hbs, vbs, ls, fs, fld, mchg;
        logic [11:0] x, y;
        int          gap, fgap;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    bit   last_hb = 1'b1;
    bit   last_vb = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_timings_mc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .timings    (timings),
        .pixel_stb  (pixel_stb),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .hblank_n   (hblank_n),
        .vblank_n   (vblank_n),
        .hblank_stb (hblank_stb),
        .vblank_stb (vblank_stb),
        .line_stb   (line_stb),
        .frame_stb  (frame_stb),
        .mode_stb   (mode_stb),
        .xpos       (xpos),
        .ypos       (ypos),
        .field      (field)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check_reset();
        chk("rst_pixel_stb", pixel_stb, 0);
        chk("rst_hsync_n", hsync_n, 1);
        chk("rst_vsync_n", vsync_n, 1);
        chk("rst_hblank_n", hblank_n, 1);
        chk("rst_vblank_n", vblank_n, 1);
        chk("rst_strobes", {hblank_stb, vblank_stb, line_stb, frame_stb, mode_stb}, 0);
        chk("rst_xpos", xpos, 0);
        chk("rst_ypos", ypos, 0);
        chk("rst_field", field, 0);
    endtask

    // Reference frame built from absolute pixel time within the frame.
    task automatic push_frame(input vt_timings_t m, input bit fld, input bit first,
                              input bit mchg, output int n);
        int   ht, lines, hoff, vs_on, vs_off, t;
        exp_t e;
        ht     = (m.htotal == 0) ? 1 : int'(m.htotal);
        lines  = (m.vtotal == 0) ? 1 : int'(m.vtotal);
        hoff   = 0;
        if (m.interlace && fld) begin
            lines = lines + 1;
            hoff  = ht / 2;
        end
        vs_on  = int'(m.vsstart) * ht + hoff;
        vs_off = int'(m.vsstop) * ht + hoff;
        n = lines * ht;
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < ht; x++) begin
                t      = y * ht + x;
                e.hb   = (x < int'(m.hbstart));
                e.vb   = (y < int'(m.vbstart));
                e.hs   = (x >= int'(m.hsstart) && x < int'(m.hsstop)) ? m.hpolarity
                                                                   : ~m.hpolarity;
                e.vs   = (t >= vs_on && t < vs_off) ? m.vpolarity : ~m.vpolarity;
                e.hbs  = last_hb && !e.hb;
                e.vbs  = last_vb && !e.vb;
                last_hb = e.hb;
                last_vb = e.vb;
                e.x    = e.hb ? 12'(x) : 12'hfff;
                e.y    = e.vb ? 12'(y) : 12'hfff;
                e.ls   = (x == ht - 1);
                e.fs   = e.ls && (y == lines - 1);
                e.fld  = fld;
                e.mchg = mchg;
                e.gap  = (first && t == 0) ? 0 : int'(m.clkdiv) + 1;
                e.fgap = (first || !e.fs) ? 0 : n * (int'(m.clkdiv) + 1);
                q.push_back(e);
            end
        end
    endtask

    // Queue one frame, then change timings to nxt once that frame is half shown.
    task automatic run_frame(input vt_timings_t m, input bit fld, input bit first,
                             input vt_timings_t nxt);
        int n;
        int budget;
        push_frame(m, fld, first, nxt != m, n);
        budget = 0;
        while (q.size() > n / 2 && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 20000) begin
            tests++;
            fails++;
            $display("FAIL frame_wait: timed out, %0d pixels still queued", q.size());
        end
        #2 timings = nxt;
    endtask

    initial begin : monitor
        exp_t e;
        int   last_px, last_fs;
        bit   mpend, mexp;
        last_px = -1;
        last_fs = -1;
        mpend   = 1'b0;
        mexp    = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_px = -1;
                last_fs = -1;
                mpend   = 1'b0;
            end else begin
                if (mpend) begin
                    chk("mode_stb_after_frame", mode_stb, mexp);
                    mpend = 1'b0;
                end else begin
                    chk("mode_stb_idle", mode_stb, 0);
                end
                if (pixel_stb) begin
                    if (q.size() == 0) begin
                        if (!done) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_pixel: got pixel_stb 1, expected none");
                        end
                    end else begin
                        e = q.pop_front();
                        chk("hsync_n", hsync_n, e.hs);
                        chk("vsync_n", vsync_n, e.vs);
                        chk("hblank_n", hblank_n, e.hb);
                        chk("vblank_n", vblank_n, e.vb);
                        chk("hblank_stb", hblank_stb, e.hbs);
                        chk("vblank_stb", vblank_stb, e.vbs);
                        chk("line_stb", line_stb, e.ls);
                        chk("frame_stb", frame_stb, e.fs);
                        chk("field", field, e.fld);
                        chk("xpos", xpos, e.x);
                        chk("ypos", ypos, e.y);
                        if (e.gap != 0) chk("pixel_period", cyc - last_px, e.gap);
                        last_px = cyc;
                        if (e.fs) begin
                            if (e.fgap != 0) chk("frame_period", cyc - last_fs, e.fgap);
                            last_fs = cyc;
                            mpend   = 1'b1;
                            mexp    = e.mchg;
                        end
                    end
                end else begin
                    chk("idle_strobes", {hblank_stb, vblank_stb, line_stb, frame_stb}, 0);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        timings = M1;
        repeat (3) @(posedge clk);
        #2 check_reset();
        reset_n = 1'b1;

        run_frame(M1, 1'b0, 1'b1, M1);
        run_frame(M1, 1'b0, 1'b0, M2);  // htotal change mid-frame
        run_frame(M2, 1'b0, 1'b0, M2);  // same set reasserted
        run_frame(M2, 1'b0, 1'b0, M3);
        run_frame(M3, 1'b0, 1'b0, M3);

        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset();
        q.delete();
        last_hb = 1'b1;
        last_vb = 1'b1;
        timings = M1;
        @(posedge clk);
        #2 reset_n = 1'b1;

`ifdef VIDEO_TIMINGS_INTERLACE_EN
        run_frame(M1, 1'b0, 1'b1, M4);
        run_frame(M4, 1'b0, 1'b0, M4);
        run_frame(M4, 1'b1, 1'b0, M4);
        run_frame(M4, 1'b0, 1'b0, M4);
`else
        run_frame(M1, 1'b0, 1'b1, M1);
        run_frame(M1, 1'b0, 1'b0, M1);
`endif

        budget = 0;
        while (q.size() != 0 && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 20000) begin
            tests++;
            fails++;
            $display("FAIL drain: timed out, %0d pixels still queued", q.size());
        end
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
